// File: rtl/uart_word_rx.sv
// Byte-to-word packer behind the UART-Lite bridge: gathers 4 byte strobes into a
// 32-bit word and queues words in a first-word-fall-through FIFO for the CPU.
module uart_word_rx #(
  parameter int DEPTH      = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [7:0]                 uart_input,
  input  logic                       uart_invalid,
  output logic                       uart_inready,
  output logic [31:0]                word_data,
  output logic                       word_valid,
  input  logic                       word_ready,
  input  logic                       flush,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshakes: a byte is taken on any cycle uart_invalid=1 (uart_inready is only
  // advisory to the bridge); a word leaves the FIFO on word_valid & word_ready.
  typedef enum logic [1:0] {IDLE, B1, B2, B3} byte_state_t;

  byte_state_t  state;
  logic [31:0]  asm_word;
  logic [31:0]  word_next;
  logic [31:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  count;
  logic         overflow_q;

  logic         full;
  logic         pop;
  logic         last_byte;
  logic         push;
  logic [1:0]   slot;
  logic [4:0]   lsb;

  assign full      = (count == FULL_CNT);
  assign pop       = word_valid & word_ready & ~flush;
  assign last_byte = uart_invalid & ~flush & (state == B3);
  // A pop in the same cycle frees the slot the completing word needs.
  assign push      = last_byte & (~full | pop);

  // Slot k lands at [31-8k:24-8k] big-endian, i.e. lsb = 8*(3-k) = {~k,3'b0}.
  always_comb begin
    word_next = asm_word;
    slot      = 2'(state);
    lsb       = BIG_ENDIAN ? {~slot, 3'b000} : {slot, 3'b000};
    word_next[lsb +: 8] = uart_input;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      asm_word   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      state      <= IDLE;
      asm_word   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (uart_invalid) begin
        if (state == B3) begin
          state    <= IDLE;
          asm_word <= '0;
          if (push) begin
            mem[wr_ptr] <= word_next;
            wr_ptr      <= wr_ptr + AW'(1);
          end else begin
            overflow_q  <= 1'b1;
          end
        end else begin
          state    <= byte_state_t'(2'(state) + 2'd1);
          asm_word <= word_next;
        end
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  assign uart_inready = rstn & ~flush & (count < FULL_CNT);
  assign word_valid   = (count != '0);
  assign word_data    = mem[rd_ptr];
  assign overflow     = overflow_q;
  assign level        = count;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: a big-endian and a little-endian instance share
// one stimulus stream; expected words are hand-written constants.
module tb_uart_word_rx;

  logic        clk;
  logic        rstn;
  logic [7:0]  uart_input;
  logic        uart_invalid;
  logic        word_ready;
  logic        flush;

  logic        uart_inready, word_valid, overflow;
  logic [31:0] word_data;
  logic [2:0]  level;
  logic        le_inready, le_valid, le_overflow;
  logic [31:0] le_data;
  logic [2:0]  le_level;

  int n_cmp = 0;
  int n_err = 0;

  uart_word_rx #(.DEPTH(4), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .uart_input(uart_input), .uart_invalid(uart_invalid),
    .uart_inready(uart_inready), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .overflow(overflow), .level(level)
  );

  uart_word_rx #(.DEPTH(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rstn(rstn), .uart_input(uart_input), .uart_invalid(uart_invalid),
    .uart_inready(le_inready), .word_data(le_data), .word_valid(le_valid),
    .word_ready(word_ready), .flush(flush), .overflow(le_overflow), .level(le_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    uart_input   = b;
    uart_invalid = 1'b1;
    @(negedge clk);
    uart_invalid = 1'b0;
    uart_input   = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic fill_fifo();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
  endtask

  // tests
  task automatic test_reset();
    rstn = 1'b0; uart_input = 8'h00; uart_invalid = 1'b0; word_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (uart_inready !== 1'b0) begin n_err++; $display("FAIL reset_inready got %b want 0", uart_inready); end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", word_valid); end
    n_cmp++; if (word_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 00000000", word_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (uart_inready !== 1'b1) begin n_err++; $display("FAIL post_reset_inready got %b want 1", uart_inready); end
  endtask

  task automatic test_basic_word();
    send_byte(8'h12, 2);
    send_byte(8'h34, 1);
    send_byte(8'h56, 3);
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL partial_valid got %b want 0", word_valid); end
    send_byte(8'h78, 0);
    n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", word_valid); end
    n_cmp++; if (word_data !== 32'h12345678) begin n_err++; $display("FAIL basic_be_data got %h want 12345678", word_data); end
    n_cmp++; if (le_data !== 32'h78563412) begin n_err++; $display("FAIL basic_le_data got %h want 78563412", le_data); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL basic_level got %0d want 1", level); end
    n_cmp++; if (uart_inready !== 1'b1) begin n_err++; $display("FAIL basic_inready got %b want 1", uart_inready); end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL basic_pop_level got %0d want 0", level); end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop_valid got %b want 0", word_valid); end
  endtask

  task automatic test_fill_and_overflow();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h00010203; exp_w[1] = 32'h04050607;
    exp_w[2] = 32'h08090A0B; exp_w[3] = 32'h0C0D0E0F;
    fill_fifo();
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_level got %0d want 4", level); end
    n_cmp++; if (uart_inready !== 1'b0) begin n_err++; $display("FAIL fill_inready got %b want 0", uart_inready); end
    send_byte(8'hE0, 0);
    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
    send_byte(8'hE3, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d want 4", level); end
    n_cmp++; if (word_data !== 32'h00010203) begin n_err++; $display("FAIL ovf_head got %h want 00010203", word_data); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 1", i, word_valid); end
      n_cmp++; if (word_data !== exp_w[i]) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, word_data, exp_w[i]); end
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", word_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    pulse_flush();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_flush got %b want 0", overflow); end
  endtask

  task automatic test_full_with_pop();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h04050607; exp_w[1] = 32'h08090A0B;
    exp_w[2] = 32'h0C0D0E0F; exp_w[3] = 32'h10111213;
    fill_fifo();
    send_byte(8'h10, 0);
    send_byte(8'h11, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    uart_input = 8'h13; uart_invalid = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    uart_invalid = 1'b0; word_ready = 1'b0; uart_input = 8'h00;
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fullpop_level got %0d want 4", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (word_data !== exp_w[i]) begin n_err++; $display("FAIL fullpop_data[%0d] got %h want %h", i, word_data, exp_w[i]); end
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
    end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL fullpop_empty got %0d want 0", level); end
  endtask

  task automatic test_flush();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    @(negedge clk);
    flush = 1'b1; uart_input = 8'h99; uart_invalid = 1'b1;
    #1;
    n_cmp++; if (uart_inready !== 1'b0) begin n_err++; $display("FAIL flush_inready got %b want 0", uart_inready); end
    @(negedge clk);
    flush = 1'b0; uart_invalid = 1'b0; uart_input = 8'h00;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level got %0d want 0", level); end
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    n_cmp++; if (word_data !== 32'hAABBCCDD) begin n_err++; $display("FAIL flush_be_data got %h want aabbccdd", word_data); end
    n_cmp++; if (le_data !== 32'hDDCCBBAA) begin n_err++; $display("FAIL flush_le_data got %h want ddccbbaa", le_data); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL flush_word_level got %0d want 1", level); end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    n_cmp++; if (word_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_rst_data got %h want deadbeef", word_data); end
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", word_valid); end
    n_cmp++; if (word_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got %h want 00000000", word_data); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_mid_level got %0d want 0", level); end
    n_cmp++; if (uart_inready !== 1'b0) begin n_err++; $display("FAIL rst_mid_inready got %b want 0", uart_inready); end
    @(negedge clk);
    rstn = 1'b1;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale_valid got %b want 0", word_valid); end
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    n_cmp++; if (word_data !== 32'h33445566) begin n_err++; $display("FAIL rst_new_data got %h want 33445566", word_data); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL rst_new_level got %0d want 1", level); end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_basic_word();
    test_fill_and_overflow();
    test_full_with_pop();
    test_flush();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
